// File: rtl/serial_booth_mac_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// serial_booth_mac_pkg : shared FSM state type and counter-width helper
// Rev 1.0
// -----------------------------------------------------------------------------
package serial_booth_mac_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RX   = 3'd1,
      ST_MUL  = 3'd2,
      ST_ACC  = 3'd3,
      ST_TX   = 3'd4
   } state_t;

   // Width of a counter that has to hold the values 0 .. n-1
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_booth_mac_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// serial_booth_mac_if : bit-serial operand/result links with valid/ready
// Rev 1.0
// -----------------------------------------------------------------------------
interface serial_booth_mac_if;
   logic i_din_a;
   logic i_din_b;
   logic i_valid;
   logic o_ready;
   logic i_signed;
   logic i_acc;
   logic o_dout;
   logic o_valid;
   logic i_ready;
   logic o_busy;

   modport master (
      output i_din_a, i_din_b, i_valid, i_signed, i_acc, i_ready,
      input  o_ready, o_dout, o_valid, o_busy
   );

   modport slave (
      input  i_din_a, i_din_b, i_valid, i_signed, i_acc, i_ready,
      output o_ready, o_dout, o_valid, o_busy
   );
endinterface
`default_nettype wire

// File: rtl/serial_booth_mac_booth_seq_mult.sv
`default_nettype none
// -----------------------------------------------------------------------------
// booth_seq_mult : iterative radix-2 Booth multiplier, one iteration per cycle
// Rev 1.0
// -----------------------------------------------------------------------------
module booth_seq_mult
   import serial_booth_mac_pkg::*;
#(
   parameter int WIDTH = 9
) (
   input  wire logic               i_clk,
   input  wire logic               i_rst,
   input  wire logic               i_en,
   input  wire logic               i_start,
   input  wire logic [WIDTH-1:0]   iv_a,
   input  wire logic [WIDTH-1:0]   iv_b,
   output logic                    o_done,
   output logic [2*WIDTH-1:0]      ov_prod
);

   localparam int P_W   = 2*WIDTH + 2;
   localparam int CNT_W = cnt_w(WIDTH + 1);

   // p = {upper partial (WIDTH+1), multiplier (WIDTH), booth q-1 bit}
   logic [P_W-1:0]   p_q, p_d;
   logic [WIDTH:0]   m_q, m_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic [WIDTH:0]   upper;
   logic [WIDTH:0]   sum;

   always_comb begin
      upper = p_q[P_W-1:WIDTH+1];
      case (p_q[1:0])
         2'b01:   sum = upper + m_q;
         2'b10:   sum = upper - m_q;
         default: sum = upper;
      endcase

      p_d    = p_q;
      m_d    = m_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (i_start) begin
         p_d   = {{(WIDTH+1){1'b0}}, iv_b, 1'b0};
         m_d   = {iv_a[WIDTH-1], iv_a};
         cnt_d = CNT_W'(WIDTH);
      end else if (cnt_q != '0) begin
         p_d    = {sum[WIDTH], sum, p_q[WIDTH:1]};
         cnt_d  = cnt_q - 1'b1;
         done_d = (cnt_q == CNT_W'(1));
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         p_q    <= '0;
         m_q    <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else if (i_en) begin
         p_q    <= p_d;
         m_q    <= m_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign o_done  = done_q;
   assign ov_prod = p_q[2*WIDTH:1];

endmodule
`default_nettype wire

// File: rtl/serial_booth_mac.sv
`default_nettype none
// -----------------------------------------------------------------------------
// serial_booth_mac : bit-serial signed/unsigned Booth multiply-accumulate top
// Rev 1.0
// -----------------------------------------------------------------------------
module serial_booth_mac
   import serial_booth_mac_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH + 4
) (
   input  wire logic          i_clk,
   input  wire logic          i_rst,
   input  wire logic          i_en,
   serial_booth_mac_if.slave  bus
);

   localparam int OP_W   = DATA_WIDTH + 1;
   localparam int PROD_W = 2*OP_W;
   localparam int RX_W   = cnt_w(DATA_WIDTH);
   localparam int TX_W   = cnt_w(ACC_WIDTH);
   localparam logic [RX_W-1:0] RX_LAST = RX_W'(DATA_WIDTH - 1);
   localparam logic [TX_W-1:0] TX_LAST = TX_W'(ACC_WIDTH - 1);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d;
   logic [RX_W-1:0]       rx_cnt_q, rx_cnt_d;
   logic [TX_W-1:0]       tx_idx_q, tx_idx_d;
   logic                  signed_q, signed_d;
   logic                  accm_q, accm_d;
   logic [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic                  ready_q, ready_d;
   logic                  valid_q, valid_d;
   logic                  dout_q, dout_d;
   logic                  busy_q, busy_d;

   logic                  in_xfer, out_xfer, mul_start, mul_done;
   logic [OP_W-1:0]       op_a, op_b;
   logic [PROD_W-1:0]     prod;
   logic [ACC_WIDTH-1:0]  prod_ext;

   assign in_xfer  = i_en & bus.i_valid & ready_q;
   assign out_xfer = i_en & valid_q & bus.i_ready;
   assign prod_ext = ACC_WIDTH'($signed(prod));

   // Operands go to the multiplier on the same edge the last bit lands
   assign op_a = signed_q ? {a_sr_d[DATA_WIDTH-1], a_sr_d} : {1'b0, a_sr_d};
   assign op_b = signed_q ? {b_sr_d[DATA_WIDTH-1], b_sr_d} : {1'b0, b_sr_d};

   always_comb begin
      state_d   = state_q;
      a_sr_d    = a_sr_q;
      b_sr_d    = b_sr_q;
      rx_cnt_d  = rx_cnt_q;
      tx_idx_d  = tx_idx_q;
      signed_d  = signed_q;
      accm_d    = accm_q;
      acc_d     = acc_q;
      mul_start = 1'b0;

      case (state_q)
         ST_IDLE: if (in_xfer) begin
            a_sr_d   = {bus.i_din_a, a_sr_q[DATA_WIDTH-1:1]};
            b_sr_d   = {bus.i_din_b, b_sr_q[DATA_WIDTH-1:1]};
            signed_d = bus.i_signed;
            accm_d   = bus.i_acc;
            rx_cnt_d = RX_W'(1);
            state_d  = ST_RX;
         end
         ST_RX: if (in_xfer) begin
            a_sr_d = {bus.i_din_a, a_sr_q[DATA_WIDTH-1:1]};
            b_sr_d = {bus.i_din_b, b_sr_q[DATA_WIDTH-1:1]};
            if (rx_cnt_q == RX_LAST) begin
               rx_cnt_d  = '0;
               mul_start = 1'b1;
               state_d   = ST_MUL;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         ST_MUL: if (mul_done) state_d = ST_ACC;
         ST_ACC: begin
            acc_d    = (accm_q ? acc_q : '0) + prod_ext;
            tx_idx_d = '0;
            state_d  = ST_TX;
         end
         ST_TX: if (out_xfer) begin
            if (tx_idx_q == TX_LAST) begin
               tx_idx_d = '0;
               state_d  = ST_IDLE;
            end else begin
               tx_idx_d = tx_idx_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ready_d = (state_d == ST_IDLE) || (state_d == ST_RX);
      valid_d = (state_d == ST_TX);
      dout_d  = (state_d == ST_TX) ? acc_d[tx_idx_d] : 1'b0;
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         rx_cnt_q <= '0;
         tx_idx_q <= '0;
         signed_q <= 1'b0;
         accm_q   <= 1'b0;
         acc_q    <= '0;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
         dout_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else if (i_en) begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         rx_cnt_q <= rx_cnt_d;
         tx_idx_q <= tx_idx_d;
         signed_q <= signed_d;
         accm_q   <= accm_d;
         acc_q    <= acc_d;
         ready_q  <= ready_d;
         valid_q  <= valid_d;
         dout_q   <= dout_d;
         busy_q   <= busy_d;
      end
   end

   booth_seq_mult #(
      .WIDTH (OP_W)
   ) u_mult (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (i_en),
      .i_start (mul_start),
      .iv_a    (op_a),
      .iv_b    (op_b),
      .o_done  (mul_done),
      .ov_prod (prod)
   );

   assign bus.o_ready = ready_q;
   assign bus.o_valid = valid_q;
   assign bus.o_dout  = dout_q;
   assign bus.o_busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_booth_mac.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_serial_booth_mac : randomized self-checking bench with a word-level MAC model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_serial_booth_mac;

   localparam int DW = 4;
   localparam int AW = 12;

   logic clk = 1'b0;
   logic rst;
   logic en;
   always #5 clk = ~clk;

   serial_booth_mac_if bus();

   serial_booth_mac #(
      .DATA_WIDTH (DW),
      .ACC_WIDTH  (AW)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .i_en  (en),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_acc_cyc = 0;
   int model_acc = 0;
   int exp_q[$];
   int ready_mode = 0;
   logic manual_ready = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Downstream ready: always high, random, or under direct test control
   initial begin
      bus.i_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            1:       bus.i_ready = ($urandom_range(2) != 0);
            2:       bus.i_ready = manual_ready;
            default: bus.i_ready = 1'b1;
         endcase
      end
   end

   // Output monitor: collects serial words, checks them against the model queue
   int         bitcnt = 0;
   logic [AW-1:0] word;
   bit         stall_prev = 1'b0;
   logic       dout_prev;
   always @(negedge clk) begin
      if (rst !== 1'b0) begin
         bitcnt     = 0;
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_valid_hold", {31'd0, bus.o_valid}, 32'd1);
            check("stall_dout_hold", {31'd0, bus.o_dout}, {31'd0, dout_prev});
         end
         if (bus.o_valid === 1'b1)
            check("ready_low_in_tx", {31'd0, bus.o_ready}, 32'd0);
         if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1 && en === 1'b1) begin
            word[bitcnt] = bus.o_dout;
            bitcnt++;
            if (bitcnt == AW) begin
               bitcnt = 0;
               if (exp_q.size() == 0)
                  check("word_unexpected", {20'd0, word}, 32'hFFFF_FFFF);
               else
                  check("word", {20'd0, word}, exp_q.pop_front());
            end
         end
         stall_prev = (bus.o_valid === 1'b1) && !(bus.i_ready === 1'b1 && en === 1'b1);
         dout_prev  = bus.o_dout;
      end
   end

   // Word-level model: plain integer multiply, add, reduce modulo 2^AW
   task automatic send_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input bit sgn, input bit accm, input int gap_pct);
      int av, bv, w;
      av = (sgn && a[DW-1]) ? int'(a) - (1 << DW) : int'(a);
      bv = (sgn && b[DW-1]) ? int'(b) - (1 << DW) : int'(b);
      model_acc = ((accm ? model_acc : 0) + av * bv) & ((1 << AW) - 1);
      exp_q.push_back(model_acc);
      for (int i = 0; i < DW; i++) begin
         for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++) begin
            bus.i_valid = 1'b0;
            bus.i_din_a = 1'($urandom);
            bus.i_din_b = 1'($urandom);
            tick();
         end
         bus.i_valid  = 1'b1;
         bus.i_din_a  = a[i];
         bus.i_din_b  = b[i];
         bus.i_signed = (i == 0) ? sgn  : 1'($urandom);
         bus.i_acc    = (i == 0) ? accm : 1'($urandom);
         w = 0;
         while (bus.o_ready !== 1'b1 && w < 300) begin
            tick();
            w++;
         end
         if (w >= 300) check("rx_ready_timeout", {31'd0, bus.o_ready}, 32'd1);
         tick();
         last_acc_cyc = cyc;
         bus.i_valid = 1'b0;
      end
   endtask

   task automatic pin(input string name, input int lit);
      check(name, model_acc, lit);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || bus.o_busy !== 1'b0) && n < 400) begin
         tick();
         n++;
      end
      if (n >= 400) check("idle_timeout", exp_q.size(), 0);
   endtask

   task automatic wait_valid(input int exp_lat);
      int n = 0;
      int rdy_seen = 0;
      while (bus.o_valid !== 1'b1 && n < 100) begin
         if (bus.o_ready !== 1'b0) rdy_seen++;
         tick();
         n++;
      end
      check("latency", cyc - last_acc_cyc, exp_lat);
      check("ready_low_in_mul", rdy_seen, 0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ready"}, {31'd0, bus.o_ready}, 32'd1);
      check({tag, "_valid"}, {31'd0, bus.o_valid}, 32'd0);
      check({tag, "_dout"},  {31'd0, bus.o_dout},  32'd0);
      check({tag, "_busy"},  {31'd0, bus.o_busy},  32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      en  = 1'b1;
      bus.i_valid  = 1'b0;
      bus.i_din_a  = 1'b0;
      bus.i_din_b  = 1'b0;
      bus.i_signed = 1'b0;
      bus.i_acc    = 1'b0;
      repeat (3) tick();
      check_idle_outputs("reset");
      rst = 1'b0;
      tick();

      // Directed cases with hand-computed results
      send_op(4'b1000, 4'b1000, 1'b1, 1'b0, 0);  pin("pin_m8xm8", 'h040);
      send_op(4'hF, 4'hF, 1'b0, 1'b0, 0);        pin("pin_15x15", 'h0E1);
      send_op(4'hF, 4'hF, 1'b1, 1'b0, 0);        pin("pin_m1xm1", 'h001);
      send_op(4'd7, 4'b1101, 1'b1, 1'b0, 0);     pin("pin_7xm3", 'hFEB);
      wait_valid(DW + 3);
      send_op(4'd2, 4'd2, 1'b1, 1'b1, 0);        pin("pin_acc_m17", 'hFEF);
      send_op(4'd3, 4'd5, 1'b0, 1'b0, 0);        pin("pin_3x5", 'h00F);
      send_op(4'd2, 4'd2, 1'b0, 1'b1, 0);        pin("pin_acc_19", 'h013);
      send_op(4'hF, 4'hF, 1'b0, 1'b0, 0);
      for (int k = 0; k < 18; k++) send_op(4'hF, 4'hF, 1'b0, 1'b1, 0);
      pin("pin_wrap", 'h0B3);
      wait_idle();

      // Backpressure mid-TX and input gaps
      ready_mode   = 2;
      manual_ready = 1'b1;
      send_op(4'b1000, 4'b1000, 1'b1, 1'b0, 60);
      for (int n = 0; n < 100 && bus.o_valid !== 1'b1; n++) tick();
      repeat (3) tick();
      manual_ready = 1'b0;
      repeat (6) tick();
      manual_ready = 1'b1;
      wait_idle();
      ready_mode = 0;

      // Reset during RX after two bits
      bus.i_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.i_din_a = 1'b1;
         bus.i_din_b = 1'b1;
         tick();
      end
      bus.i_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_acc = 0;
      check_idle_outputs("rst_rx");
      send_op(4'd3, 4'd5, 1'b0, 1'b1, 0);        pin("pin_after_rst_rx", 'h00F);
      wait_idle();

      // Reset during TX
      send_op(4'd7, 4'd3, 1'b0, 1'b0, 0);
      for (int n = 0; n < 100 && bus.o_valid !== 1'b1; n++) tick();
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      model_acc = 0;
      check_idle_outputs("rst_tx");
      send_op(4'd2, 4'd3, 1'b0, 1'b1, 0);        pin("pin_after_rst_tx", 'h006);
      wait_idle();

      // Enable low during MUL stretches latency cycle-for-cycle
      send_op(4'd3, 4'd3, 1'b0, 1'b0, 0);
      tick();
      en = 1'b0;
      repeat (3) tick();
      en = 1'b1;
      wait_valid(DW + 3 + 3);
      wait_idle();

      // Randomized operations with random downstream stalls and input gaps
      ready_mode = 1;
      for (int k = 0; k < 40; k++)
         send_op(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 30);
      wait_idle();
      ready_mode = 0;
      repeat (3) tick();
      check_idle_outputs("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
